spindle_index_gen: RTL and testbench
====================================

// Module: spindle_index_gen
// PURPOSE
// - Drive-to-host half of the spindle interface. Emulates the rotating disk's timing back to the host:
//   index pulse (bus pin 8) once per revolution and ready (pin 34) after spin-up.
// - Shares the host motor_on / dens_sel inputs with the spindle enable/speed logic.
// - rev_strobe marks revolution start for the read-data path.
// PARAMETERS
// - REV_300_CYC   2_400_000  clocks per revolution at 300 rpm (12 MHz clock, 200 ms)
// - REV_360_CYC   2_000_000  clocks per revolution at 360 rpm (166.67 ms)
// - INDEX_PW_CYC  24_000     index low width in clocks (2 ms); must be < REV_360_CYC
// - SPINUP_REVS   3          complete revolutions before ready_n asserts; must be >= 1
// - CNT_W         22         phase counter width; 2**CNT_W > REV_300_CYC
// PORTS
// - clk           in   1      system clock
// - rst_n         in   1      synchronous, active-low reset
// - motor_on_n    in   1      host pin 16, active-low, asynchronous to clk
// - dens_sel      in   1      host pin 2; 1 = 360 rpm, 0 = 300 rpm; asynchronous
// - disk_present  in   1      drive-side media sense, 1 = disk inserted; asynchronous
// - index_n       out  1      index pulse to host, active-low
// - ready_n       out  1      drive ready to host, active-low
// - rev_strobe    out  1      one-clock pulse on the first cycle of each revolution
// BEHAVIOUR
// - All three async inputs pass through 2-flop synchronizers. All outputs are registered.
// - Reset: index_n=1, ready_n=1, rev_strobe=0, state=IDLE, phase=0, rev_cnt=0.
//   Synchronizer flops reset to the inactive values: motor_on_n=1, disk_present=0.
// - run = ~motor_on_n_s & disk_present_s.
// - FSM:
//   - IDLE: phase held at 0, outputs inactive. run=1 -> SPINUP.
//   - SPINUP: phase counts. Each completed revolution increments rev_cnt.
//     rev_cnt reaches SPINUP_REVS at a revolution end -> RUN.
//   - RUN: ready_n=0. Phase keeps counting.
//   - Any state: run=0 -> IDLE next cycle; index_n, ready_n and rev_strobe deassert on that edge.
//     phase and rev_cnt are cleared. This also applies mid-pulse and mid-spin-up.
// - Revolution period:
//   - period = spd_lat ? REV_360_CYC : REV_300_CYC.
//   - spd_lat is loaded from dens_sel_s on IDLE->SPINUP and at every revolution boundary.
//   - phase counts 0..period-1, then wraps to 0. That cycle is the boundary.
// - Speed change: at a boundary, if dens_sel_s != spd_lat:
//   - load the new spd_lat;
//   - return to SPINUP with rev_cnt=0;
//   - ready_n deasserts on the same edge.
//   dens_sel changes within a revolution have no effect until the next boundary.
// - Index pulse:
//   - index_n=0 while state != IDLE and phase < INDEX_PW_CYC.
//   - Index pulses are emitted during SPINUP as well.
// - rev_strobe=1 exactly when phase==0 in SPINUP/RUN. It coincides with index_n falling.
// - Latency: motor_on_n low (disk present, IDLE) -> index_n low and rev_strobe high on the
//   3rd rising edge (2 sync + 1 FSM/output register). De-assertion also takes 3 edges.
// - ready_n falls on the same edge as the rev_strobe that begins revolution SPINUP_REVS+1.
// - Simultaneous events:
//   - run=0 overrides a boundary or speed change in the same cycle.
//   - Reset overrides everything.
// STRUCTURE
// - Shared package floppy_pkg holds:
//   - state encoding (IDLE/SPINUP/RUN);
//   - default cycle constants for a 12 MHz clock;
//   - the RPM-select polarity constant (1 = 360).
// - Sub-module sync2 (2-flop synchronizer, reset value parameter), instantiated 3x.
//   The FSM, phase counter and rev counter stay in this module.
// TESTING (bench params: REV_300_CYC=100, REV_360_CYC=80, INDEX_PW_CYC=4, SPINUP_REVS=2)
// - Reset held, then released with motor_on_n=1 -> index_n=1, ready_n=1, rev_strobe=0 indefinitely.
// - disk_present=1, dens_sel=0, motor_on_n falls at edge 0:
//   - index_n low on edges 3..6, then again every 100 clocks;
//   - rev_strobe on edges 3, 103, 203;
//   - ready_n falls at edge 203.
// - Same as above with dens_sel=1: period 80, rev_strobe at 3/83/163, ready_n falls at 163.
// - In RUN at 300 rpm, toggle dens_sel to 1 at phase 50:
//   - no change until the boundary;
//   - at the boundary ready_n=1 and the period becomes 80;
//   - ready_n returns low 2 revolutions later.
// - Raise motor_on_n during an index pulse (phase 2) -> 3 edges later index_n=1, ready_n=1, state IDLE.
//   A re-enable restarts spin-up with rev_cnt=0.
// - Drop disk_present in RUN -> same as motor-off. Assert rst_n=0 mid-SPINUP -> all outputs
//   inactive on the next edge.

Source files
------------

// File: rtl/floppy_pkg.sv
// Shared floppy-drive definitions: spindle FSM encoding, 12 MHz timing defaults, RPM select polarity.
package floppy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2
  } spindle_state_e;

  // Default cycle counts for a 12 MHz system clock
  localparam int unsigned REV_300_CYC_DEF  = 2_400_000;
  localparam int unsigned REV_360_CYC_DEF  = 2_000_000;
  localparam int unsigned INDEX_PW_CYC_DEF = 24_000;
  localparam int unsigned SPINUP_REVS_DEF  = 3;
  localparam int unsigned CNT_W_DEF        = 22;

  // dens_sel level that selects 360 rpm
  localparam logic RPM_360_SEL = 1'b1;

endpackage : floppy_pkg

// File: rtl/spindle_index_gen_if.sv
// Host-facing spindle signals: host drives motor/density/media inputs, drive returns index/ready/strobe.
interface spindle_index_gen_if;
  logic motor_on_n;
  logic dens_sel;
  logic disk_present;
  logic index_n;
  logic ready_n;
  logic rev_strobe;

  modport master (
    output motor_on_n, dens_sel, disk_present,
    input  index_n, ready_n, rev_strobe
  );

  modport slave (
    input  motor_on_n, dens_sel, disk_present,
    output index_n, ready_n, rev_strobe
  );
endinterface : spindle_index_gen_if

// File: rtl/spindle_index_gen_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values for the two synchronizer stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, reset to the inactive level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync2

// File: rtl/spindle_index_gen.sv
// Emulates disk rotation timing to the host: index pulse per revolution, ready after spin-up.
module spindle_index_gen
  import floppy_pkg::*;
#(
  parameter int unsigned REV_300_CYC  = REV_300_CYC_DEF,
  parameter int unsigned REV_360_CYC  = REV_360_CYC_DEF,
  parameter int unsigned INDEX_PW_CYC = INDEX_PW_CYC_DEF,
  parameter int unsigned SPINUP_REVS  = SPINUP_REVS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  spindle_index_gen_if.slave bus
);

  localparam int unsigned REV_W = $clog2(SPINUP_REVS + 1);

  logic motor_on_n_s, dens_sel_s, disk_present_s;
  logic run;

  spindle_state_e   state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
  logic             spd_q, spd_d;
  logic             index_n_q, index_n_d;
  logic             ready_n_q, ready_n_d;
  logic             rev_strobe_q, rev_strobe_d;
  logic [CNT_W-1:0] period_m1;
  logic             boundary;

  sync2 #(.RST_VAL(1'b1)) u_sync_motor (
    .clk(clk), .rst_n(rst_n), .d(bus.motor_on_n), .q(motor_on_n_s)
  );
  sync2 #(.RST_VAL(1'b0)) u_sync_dens (
    .clk(clk), .rst_n(rst_n), .d(bus.dens_sel), .q(dens_sel_s)
  );
  sync2 #(.RST_VAL(1'b0)) u_sync_disk (
    .clk(clk), .rst_n(rst_n), .d(bus.disk_present), .q(disk_present_s)
  );

  assign run       = ~motor_on_n_s & disk_present_s;
  assign period_m1 = (spd_q == RPM_360_SEL) ? CNT_W'(REV_360_CYC - 1) : CNT_W'(REV_300_CYC - 1);
  assign boundary  = (phase_q == period_m1);

  // Next state, phase/revolution counting, speed latch and registered output values
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rev_cnt_d = rev_cnt_q;
    spd_d     = spd_q;

    case (state_q)
      ST_IDLE: begin
        phase_d   = '0;
        rev_cnt_d = '0;
        if (run) begin
          state_d = ST_SPINUP;
          spd_d   = dens_sel_s;
        end
      end
      default: begin
        if (boundary) begin
          phase_d = '0;
          spd_d   = dens_sel_s;
          if (dens_sel_s != spd_q) begin
            // Speed change: re-qualify the new rotation rate from scratch
            state_d   = ST_SPINUP;
            rev_cnt_d = '0;
          end else if (state_q == ST_SPINUP) begin
            rev_cnt_d = rev_cnt_q + REV_W'(1);
            if (rev_cnt_d == REV_W'(SPINUP_REVS)) begin
              state_d = ST_RUN;
            end
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
    endcase

    // Loss of motor or media wins over any boundary event
    if (!run) begin
      state_d   = ST_IDLE;
      phase_d   = '0;
      rev_cnt_d = '0;
    end

    index_n_d    = ~((state_d != ST_IDLE) && (phase_d < CNT_W'(INDEX_PW_CYC)));
    ready_n_d    = ~(state_d == ST_RUN);
    rev_strobe_d = (state_d != ST_IDLE) && (phase_d == '0);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      rev_cnt_q    <= '0;
      spd_q        <= 1'b0;
      index_n_q    <= 1'b1;
      ready_n_q    <= 1'b1;
      rev_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rev_cnt_q    <= rev_cnt_d;
      spd_q        <= spd_d;
      index_n_q    <= index_n_d;
      ready_n_q    <= ready_n_d;
      rev_strobe_q <= rev_strobe_d;
    end
  end

  assign bus.index_n    = index_n_q;
  assign bus.ready_n    = ready_n_q;
  assign bus.rev_strobe = rev_strobe_q;

endmodule : spindle_index_gen

// File: tb/tb_spindle_index_gen.sv
// Directed bench for spindle_index_gen with short revolution periods.
module tb_spindle_index_gen;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  spindle_index_gen_if bus ();

  spindle_index_gen #(
    .REV_300_CYC (100),
    .REV_360_CYC (80),
    .INDEX_PW_CYC(4),
    .SPINUP_REVS (2),
    .CNT_W       (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic dens;
    int   e;
    logic ei;
    logic er;
    logic es;
  } vec_t;

  vec_t tbl[$];

  // One clock edge; outputs are sampled and inputs driven 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic chk(input string nm, input logic ei, input logic er, input logic es);
    n_cmp++;
    if ({bus.index_n, bus.ready_n, bus.rev_strobe} !== {ei, er, es}) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got index_n/ready_n/rev_strobe=%b%b%b, want %b%b%b",
               nm, cyc, bus.index_n, bus.ready_n, bus.rev_strobe, ei, er, es);
    end
  endtask

  // Park in IDLE with the requested density, then drop motor_on_n at edge 0
  task automatic start(input logic dens);
    bus.motor_on_n   = 1'b1;
    bus.disk_present = 1'b1;
    bus.dens_sel     = dens;
    repeat (8) tick();
    bus.motor_on_n = 1'b0;
    cyc = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.motor_on_n   = 1'b1;
    bus.dens_sel     = 1'b0;
    bus.disk_present = 1'b0;

    // Reset state, then idle with motor off
    repeat (3) tick();
    chk("reset", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    bus.disk_present = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_motor_off", 1'b1, 1'b1, 1'b0);
    end

    // Spin-up/run timing at both speeds
    tbl.push_back('{1'b0,   2, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0,   3, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0,   4, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0,   6, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0,   7, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 102, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 103, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 106, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 107, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 202, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 203, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 204, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 207, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 303, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1,   2, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1,   3, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1,   6, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1,   7, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1,  82, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1,  83, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 162, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 163, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 164, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 243, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].e <= tbl[i-1].e) start(tbl[i].dens);
      run_to(tbl[i].e);
      chk(tbl[i].dens ? "tbl_360" : "tbl_300", tbl[i].ei, tbl[i].er, tbl[i].es);
    end

    // Density change mid-revolution takes effect only at the boundary
    start(1'b0);
    run_to(203);
    chk("spd_run", 1'b0, 1'b0, 1'b1);
    run_to(353);
    chk("spd_phase50", 1'b1, 1'b0, 1'b0);
    bus.dens_sel = 1'b1;
    run_to(380);
    chk("spd_no_early", 1'b1, 1'b0, 1'b0);
    run_to(402);
    chk("spd_pre_bound", 1'b1, 1'b0, 1'b0);
    run_to(403);
    chk("spd_bound", 1'b0, 1'b1, 1'b1);
    run_to(482);
    chk("spd_p80_pre", 1'b1, 1'b1, 1'b0);
    run_to(483);
    chk("spd_p80", 1'b0, 1'b1, 1'b1);
    run_to(562);
    chk("spd_rdy_pre", 1'b1, 1'b1, 1'b0);
    run_to(563);
    chk("spd_rdy", 1'b0, 1'b0, 1'b1);

    // Motor off during the very first index pulse cuts it short
    start(1'b0);
    run_to(3);
    chk("cut_start", 1'b0, 1'b1, 1'b1);
    bus.motor_on_n = 1'b1;
    run_to(5);
    chk("cut_hold", 1'b0, 1'b1, 1'b0);
    run_to(6);
    chk("cut_off", 1'b1, 1'b1, 1'b0);
    run_to(103);
    chk("cut_no_strobe", 1'b1, 1'b1, 1'b0);

    // Motor off at phase 2 in RUN, then re-enable restarts spin-up
    start(1'b0);
    run_to(305);
    chk("moff_ph2", 1'b0, 1'b0, 1'b0);
    bus.motor_on_n = 1'b1;
    run_to(307);
    chk("moff_lat", 1'b1, 1'b0, 1'b0);
    run_to(308);
    chk("moff_off", 1'b1, 1'b1, 1'b0);
    run_to(403);
    chk("moff_idle", 1'b1, 1'b1, 1'b0);
    bus.motor_on_n = 1'b0;
    cyc = 0;
    run_to(3);
    chk("reen_start", 1'b0, 1'b1, 1'b1);
    run_to(103);
    chk("reen_rev2", 1'b0, 1'b1, 1'b1);
    run_to(202);
    chk("reen_rdy_pre", 1'b1, 1'b1, 1'b0);
    run_to(203);
    chk("reen_rdy", 1'b0, 1'b0, 1'b1);

    // Media removal in RUN behaves like motor off
    start(1'b0);
    run_to(250);
    chk("disk_run", 1'b1, 1'b0, 1'b0);
    bus.disk_present = 1'b0;
    run_to(252);
    chk("disk_lat", 1'b1, 1'b0, 1'b0);
    run_to(253);
    chk("disk_off", 1'b1, 1'b1, 1'b0);
    run_to(303);
    chk("disk_idle", 1'b1, 1'b1, 1'b0);
    bus.disk_present = 1'b1;

    // Synchronous reset mid-spin-up, during an index pulse
    start(1'b0);
    run_to(104);
    chk("rst_pre", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    run_to(105);
    chk("rst_now", 1'b1, 1'b1, 1'b0);
    run_to(106);
    rst_n = 1'b1;
    run_to(108);
    chk("rst_resync", 1'b1, 1'b1, 1'b0);
    run_to(109);
    chk("rst_restart", 1'b0, 1'b1, 1'b1);
    run_to(309);
    chk("rst_rdy", 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_spindle_index_gen
